// File: rtl/shiftreg_univ.sv
// ---------------------------------------------------------------------------
// shiftreg_univ
//   Universal shift register with parallel load and multi-step shift engine.
//   A start request latches a mode and a step count. One single-bit step
//   (SHL, SHR, ROL or ROR) is then applied per clock until the count runs out,
//   followed by a one-cycle done pulse. A load during an operation aborts it.
//
// Ports
//   clk    in   1      rising-edge clock
//   rst    in   1      synchronous active-high reset
//   load   in   1      parallel load request (also aborts a running shift)
//   val    in   WIDTH  parallel load data
//   start  in   1      begin a multi-step shift (ignored while busy)
//   mode   in   2      00 SHL, 01 SHR, 10 ROL, 11 ROR
//   amt    in   CNT_W  number of single-bit steps
//   din    in   1      serial input for SHL/SHR, sampled at each step edge
//   dout   out  WIDTH  register contents
//   sout   out  1      bit expelled by the most recent step
//   busy   out  1      shift operation in progress
//   done   out  1      one-cycle completion pulse
// ---------------------------------------------------------------------------
module shiftreg_univ #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] val,
    input  logic             start,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic             din,
    output logic [WIDTH-1:0] dout,
    output logic             sout,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] MODE_SHL = 2'b00;
    localparam logic [1:0] MODE_SHR = 2'b01;
    localparam logic [1:0] MODE_ROL = 2'b10;
    localparam logic [1:0] MODE_ROR = 2'b11;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] dout_q,  dout_d;
    logic             sout_q,  sout_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [1:0]       mode_q,  mode_d;

    // Single-bit step result for the latched mode
    logic [WIDTH-1:0] step_dout;
    logic             step_sout;

    always_comb begin
        step_dout = dout_q;
        step_sout = sout_q;
        case (mode_q)
            MODE_SHL: begin
                step_dout = {dout_q[WIDTH-2:0], din};
                step_sout = dout_q[WIDTH-1];
            end
            MODE_SHR: begin
                step_dout = {din, dout_q[WIDTH-1:1]};
                step_sout = dout_q[0];
            end
            MODE_ROL: begin
                step_dout = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
                step_sout = dout_q[WIDTH-1];
            end
            MODE_ROR: begin
                step_dout = {dout_q[0], dout_q[WIDTH-1:1]};
                step_sout = dout_q[0];
            end
            default: begin
                step_dout = dout_q;
                step_sout = sout_q;
            end
        endcase
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        dout_d  = dout_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        cnt_d   = cnt_q;
        mode_d  = mode_q;

        case (state_q)
            IDLE: begin
                if (load) begin
                    // Load wins over a simultaneous start; the start is dropped
                    dout_d = val;
                end else if (start) begin
                    if (amt == CNT_W'(0)) begin
                        // Zero-length operation: completes immediately
                        done_d = 1'b1;
                    end else begin
                        mode_d  = mode;
                        cnt_d   = amt;
                        state_d = SHIFT;
                        busy_d  = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (load) begin
                    // Abort: take the new value, no completion pulse
                    dout_d  = val;
                    cnt_d   = CNT_W'(0);
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    dout_d = step_dout;
                    sout_d = step_sout;
                    cnt_d  = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            dout_q  <= '0;
            sout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
            mode_q  <= MODE_SHL;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            sout_q  <= sout_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign dout = dout_q;
    assign sout = sout_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_shiftreg_univ.sv
// ---------------------------------------------------------------------------
// tb_shiftreg_univ
//   Directed scenarios followed by randomized traffic. The driver applies one
//   input vector per cycle, advances a behavioural model and queues the
//   expected outputs; an independent monitor compares after each edge.
// ---------------------------------------------------------------------------
module tb_shiftreg_univ;

    localparam int unsigned WIDTH = 4;
    localparam int unsigned CNT_W = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             load;
    logic [WIDTH-1:0] val;
    logic             start;
    logic [1:0]       mode;
    logic [CNT_W-1:0] amt;
    logic             din;
    logic [WIDTH-1:0] dout;
    logic             sout;
    logic             busy;
    logic             done;

    always #5 clk = ~clk;

    shiftreg_univ #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .val   (val),
        .start (start),
        .mode  (mode),
        .amt   (amt),
        .din   (din),
        .dout  (dout),
        .sout  (sout),
        .busy  (busy),
        .done  (done)
    );

    typedef struct {
        logic [WIDTH-1:0] dout;
        logic             sout;
        logic             busy;
        logic             done;
        string            tag;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Behavioural model: integer register value plus steps still to perform
    int m_dout = 0;
    int m_sout = 0;
    int m_done = 0;
    int m_rem  = 0;
    int m_mode = 0;

    function automatic void model_edge(input int r, input int l, input int v,
                                       input int s, input int md, input int a,
                                       input int d);
        int full;
        int msb;
        full = 1 << WIDTH;
        msb  = 1 << (WIDTH - 1);
        if (r != 0) begin
            m_dout = 0; m_sout = 0; m_done = 0; m_rem = 0;
        end else begin
            m_done = 0;
            if (m_rem == 0) begin
                if (l != 0) m_dout = v;
                else if (s != 0) begin
                    if (a == 0) m_done = 1;
                    else begin
                        m_rem  = a;
                        m_mode = md;
                    end
                end
            end else if (l != 0) begin
                m_dout = v;
                m_rem  = 0;
            end else begin
                case (m_mode)
                    0: begin m_sout = m_dout / msb; m_dout = (m_dout * 2) % full + d; end
                    1: begin m_sout = m_dout % 2;   m_dout = m_dout / 2 + d * msb; end
                    2: begin m_sout = m_dout / msb; m_dout = (m_dout * 2) % full + m_sout; end
                    default: begin m_sout = m_dout % 2; m_dout = m_dout / 2 + m_sout * msb; end
                endcase
                m_rem = m_rem - 1;
                if (m_rem == 0) m_done = 1;
            end
        end
    endfunction

    task automatic drive(input logic r, input logic l, input logic [WIDTH-1:0] v,
                         input logic s, input logic [1:0] md,
                         input logic [CNT_W-1:0] a, input logic d, input string tag);
        exp_t e;
        @(negedge clk);
        rst = r; load = l; val = v; start = s; mode = md; amt = a; din = d;
        model_edge(int'(r), int'(l), int'(v), int'(s), int'(md), int'(a), int'(d));
        e.dout = WIDTH'(m_dout);
        e.sout = (m_sout != 0);
        e.busy = (m_rem != 0);
        e.done = (m_done != 0);
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic idle(input logic d, input string tag);
        drive(1'b0, 1'b0, '0, 1'b0, 2'b00, '0, d, tag);
    endtask

    task automatic do_load(input logic [WIDTH-1:0] v, input string tag);
        drive(1'b0, 1'b1, v, 1'b0, 2'b00, '0, 1'b0, tag);
    endtask

    task automatic do_start(input logic [1:0] md, input logic [CNT_W-1:0] a,
                            input logic d, input string tag);
        drive(1'b0, 1'b0, '0, 1'b1, md, a, d, tag);
    endtask

    // Monitor: compare DUT outputs just after each rising edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (dout !== e.dout || sout !== e.sout || busy !== e.busy || done !== e.done) begin
                    errors++;
                    $display("FAIL %s t=%0t: got dout=%b sout=%b busy=%b done=%b, expected dout=%b sout=%b busy=%b done=%b",
                             e.tag, $time, dout, sout, busy, done, e.dout, e.sout, e.busy, e.done);
                end
            end
        end
    end

    initial begin : stimulus
        int waited;
        rst = 1'b1; load = 1'b0; val = '0; start = 1'b0; mode = 2'b00; amt = '0; din = 1'b0;

        // Reset from power-up, then reset from an arbitrary mid-operation state
        drive(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, 1'b0, "reset_init");
        drive(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, 1'b0, "reset_init");
        do_load(4'b1011, "pre_reset_load");
        do_start(2'b10, 3'd3, 1'b0, "pre_reset_start");
        idle(1'b1, "pre_reset_step");
        drive(1'b1, 1'b1, 4'b1111, 1'b1, 2'b01, 3'd2, 1'b1, "reset_two_cycles");
        drive(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, 1'b0, "reset_two_cycles");

        // SHL by one with din=0
        do_load(4'b0111, "shl1_load");
        do_start(2'b00, 3'd1, 1'b0, "shl1_start");
        idle(1'b0, "shl1_step");
        idle(1'b0, "shl1_after");

        // ROR by two
        do_load(4'b1001, "ror2_load");
        do_start(2'b11, 3'd2, 1'b0, "ror2_start");
        idle(1'b0, "ror2_step");
        idle(1'b0, "ror2_step");
        idle(1'b0, "ror2_after");

        // SHR by three filling with din=1
        do_load(4'b0000, "shr3_load");
        do_start(2'b01, 3'd3, 1'b1, "shr3_start");
        idle(1'b1, "shr3_step");
        idle(1'b1, "shr3_step");
        idle(1'b1, "shr3_step");
        idle(1'b1, "shr3_after");

        // Zero-length start, and starts issued while busy
        do_load(4'b0101, "amt0_load");
        do_start(2'b00, 3'd0, 1'b1, "amt0_start");
        idle(1'b0, "amt0_after");
        do_start(2'b00, 3'd3, 1'b0, "busy_start");
        do_start(2'b11, 3'd0, 1'b1, "start_while_busy");
        do_start(2'b10, 3'd2, 1'b1, "start_while_busy");
        idle(1'b0, "busy_step");
        idle(1'b0, "busy_after");

        // Abort by load after two steps
        do_load(4'b0001, "abort_load");
        do_start(2'b10, 3'd5, 1'b0, "abort_start");
        idle(1'b0, "abort_step");
        idle(1'b0, "abort_step");
        do_load(4'b1010, "abort_by_load");
        idle(1'b0, "abort_after");
        idle(1'b0, "abort_after");
        idle(1'b0, "abort_after");

        // Abort by reset after two steps
        do_load(4'b0001, "rstmid_load");
        do_start(2'b10, 3'd5, 1'b0, "rstmid_start");
        idle(1'b0, "rstmid_step");
        idle(1'b0, "rstmid_step");
        drive(1'b1, 1'b0, '0, 1'b0, 2'b00, '0, 1'b0, "rstmid_reset");
        idle(1'b0, "rstmid_after");
        idle(1'b0, "rstmid_after");
        idle(1'b0, "rstmid_after");

        // Step count beyond register width with live din changes
        do_load(4'b1100, "long_load");
        do_start(2'b00, 3'd7, 1'b1, "long_start");
        for (int i = 0; i < 7; i++) idle(1'(i % 2), "long_shl_step");
        do_start(2'b11, 3'd6, 1'b0, "long_ror_start");
        for (int i = 0; i < 7; i++) idle(1'b1, "long_ror_step");

        // Load has priority over a simultaneous start
        drive(1'b0, 1'b1, 4'b0110, 1'b1, 2'b00, 3'd2, 1'b1, "load_over_start");
        idle(1'b0, "load_over_start_after");
        idle(1'b0, "load_over_start_after");

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            logic r;
            logic l;
            logic s;
            r = ($urandom_range(0, 99) < 2);
            l = ($urandom_range(0, 99) < 8);
            s = ($urandom_range(0, 99) < 35);
            drive(r, l, WIDTH'($urandom), s, 2'($urandom), CNT_W'($urandom), 1'($urandom), "random");
        end
        idle(1'b0, "drain");
        idle(1'b0, "drain");

        // Bounded wait for the monitor to consume every expectation
        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain_timeout: %0d expectations left, required 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shiftreg_univ.md
SHIFTREG_UNIV -- requirements
Module: shiftreg_univ

Interface
REQ-001 SHALL have parameter WIDTH, default 4, register width in bits (>=2).
REQ-002 SHALL have parameter CNT_W, default 3, width of shift-amount input.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port load  input  1  parallel load request.
REQ-006 SHALL have port val  input  WIDTH  parallel load data.
REQ-007 SHALL have port start  input  1  begin multi-step shift operation.
REQ-008 SHALL have port mode  input  2  00 SHL, 01 SHR, 10 ROL, 11 ROR.
REQ-009 SHALL have port amt  input  CNT_W  number of single-bit steps.
REQ-010 SHALL have port din  input  1  serial input for SHL/SHR.
REQ-011 SHALL have port dout  output  WIDTH  register contents.
REQ-012 SHALL have port sout  output  1  bit expelled by most recent step.
REQ-013 SHALL have port busy  output  1  operation in progress.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-015 SHALL implement FSM states IDLE and SHIFT; done is a registered pulse, not a state.
REQ-016 SHALL, in IDLE with load=1, set dout=val at the edge; sout, busy unchanged; done=0.
REQ-017 SHALL, in IDLE with load=0, start=1, amt=N>0 at edge k, latch mode and N, enter SHIFT, busy=1 from edge k.
REQ-018 SHALL perform exactly one step per edge k+1..k+N; at edge k+N return to IDLE, busy=0, done=1 for that cycle only.
REQ-019 SHALL, on start with amt=0, stay IDLE, leave dout/sout unchanged, pulse done=1 at the next edge.
REQ-020 SHALL define steps: SHL dout={dout[W-2:0],din}, sout=dout[W-1]; SHR dout={din,dout[W-1:1]}, sout=dout[0]; ROL dout={dout[W-2:0],dout[W-1]}, sout=dout[W-1]; ROR dout={dout[0],dout[W-1:1]}, sout=dout[0].
REQ-021 SHALL sample din live at each step edge; mode and amt changes during SHIFT are ignored.
REQ-022 SHALL allow N>WIDTH; steps continue (SHL/SHR fully flushed with din, rotates wrap modulo WIDTH).
REQ-023 SHALL ignore start while busy=1.
REQ-024 SHALL, on load=1 in SHIFT, abort: dout=val, return to IDLE, busy=0, no done pulse.
REQ-025 SHALL give load priority over start when both asserted in IDLE (start dropped).
REQ-026 SHALL hold dout and sout when IDLE and no load/start.

Reset
REQ-027 SHALL, with rst=1 at an edge, force dout=0, sout=0, busy=0, done=0, state=IDLE, step counter=0, regardless of state or other inputs.
REQ-028 SHALL give rst priority over load and start; reset mid-operation discards the operation with no done pulse.

Verification
REQ-029 SHALL cover reset: rst=1 two cycles from arbitrary state -> dout=0000, sout=0, busy=0, done=0.
REQ-030 SHALL cover load 0111, start SHL amt=1 din=0 -> one step later dout=1110, sout=0, done=1 one cycle.
REQ-031 SHALL cover load 1001, start ROR amt=2 -> dout 1100 then 0110, final sout=0, busy high exactly 2 cycles.
REQ-032 SHALL cover dout=0000, start SHR amt=3 din=1 -> 1000, 1100, 1110; sout=0; done at third step edge.
REQ-033 SHALL cover amt=0 start -> dout unchanged, busy never 1, done=1 next cycle; and start during busy ignored.
REQ-034 SHALL cover abort and reset mid-op: ROL amt=5 on 0001, load val=1010 after 2 steps -> dout=1010, busy=0, no done; repeat with rst=1 -> all outputs 0, no done.
